// File: rtl/mem_if_pkg.sv
// ============================================================================
// mem_if_pkg: shared types for the memory-handshake initiator.
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_if_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } init_state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_init_stats.sv
// ============================================================================
// mem_init_stats: saturating read/write/error response counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_init_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_fire,
    input  logic        is_write,
    input  logic        is_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] C_MAX = 16'hFFFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (rsp_fire) begin
            if (is_err) begin
                if (err_cnt != C_MAX) err_cnt <= err_cnt + 16'd1;
            end else if (is_write) begin
                if (wr_cnt != C_MAX) wr_cnt <= wr_cnt + 16'd1;
            end else begin
                if (rd_cnt != C_MAX) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_initiator.sv
// ============================================================================
// mem_initiator: requester for the single-cycle-ack memory handshake with
// timeout/retry. Define MEM_INITIATOR_STATS_EN to add response counters. Rev 1.0
// ============================================================================
`default_nettype none

module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack
`ifdef MEM_INITIATOR_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    init_state_t       state, next_state;
    mem_cmd_t          cmd, cmd_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [TRY_W-1:0]  try_cnt, try_nxt;
    logic              read_nxt, write_nxt, err_nxt;
    logic              cmd_ready_nxt, rsp_valid_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt, rdata_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= '0;
            tmo_cnt   <= '0;
            try_cnt   <= '0;
            read      <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            data_o    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= next_state;
            cmd       <= cmd_nxt;
            tmo_cnt   <= tmo_nxt;
            try_cnt   <= try_nxt;
            read      <= read_nxt;
            write     <= write_nxt;
            addr      <= addr_nxt;
            data_o    <= data_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

    always_comb begin
        next_state = state;
        cmd_nxt    = cmd;
        tmo_nxt    = tmo_cnt;
        try_nxt    = try_cnt;
        read_nxt   = read;
        write_nxt  = write;
        addr_nxt   = addr;
        data_nxt   = data_o;
        rdata_nxt  = rsp_rdata;
        err_nxt    = rsp_err;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_nxt.write = cmd_write;
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.wdata = cmd_wdata;
                    tmo_nxt       = '0;
                    try_nxt       = '0;
                    read_nxt      = !cmd_write;
                    write_nxt     = cmd_write;
                    addr_nxt      = cmd_addr;
                    data_nxt      = cmd_wdata;
                    next_state    = REQ;
                end
            end
            REQ: begin
                // An ack on the final timeout cycle still completes the request.
                if (ack) begin
                    read_nxt   = 1'b0;
                    write_nxt  = 1'b0;
                    rdata_nxt  = cmd.write ? '0 : data_i;
                    err_nxt    = 1'b0;
                    next_state = RESP;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    if (try_cnt < TRY_W'(MAX_RETRIES)) begin
                        try_nxt    = try_cnt + TRY_W'(1);
                        next_state = GAP;
                    end else begin
                        err_nxt    = 1'b1;
                        rdata_nxt  = '0;
                        next_state = RESP;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            GAP: begin
                tmo_nxt    = '0;
                read_nxt   = !cmd.write;
                write_nxt  = cmd.write;
                addr_nxt   = cmd.addr;
                data_nxt   = cmd.wdata;
                next_state = REQ;
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        cmd_ready_nxt = (next_state == IDLE);
        rsp_valid_nxt = (next_state == RESP);
    end

`ifdef MEM_INITIATOR_STATS_EN
    mem_init_stats u_stats (
        .clk      (clk),
        .rst      (rst),
        .rsp_fire (rsp_valid && rsp_ready),
        .is_write (cmd.write),
        .is_err   (rsp_err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt),
        .err_cnt  (err_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_initiator.sv
// ============================================================================
// tb_mem_initiator: self-checking bench with a live 32x8 responder and a
// behavioural model of expected responses and latencies. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_initiator;

    localparam int TMO  = 16;
    localparam int MAXR = 2;
    // Accept edge counts as edge 0; a fully failed command answers after this many edges.
    localparam int ERR_LAT = (MAXR + 1) * TMO + MAXR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [7:0] rsp_rdata;
    logic       read, write, ack;
    logic [4:0] addr;
    logic [7:0] data_o, data_i;
`ifdef MEM_INITIATOR_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif

    mem_initiator #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .read(read), .write(write), .addr(addr), .data_o(data_o), .data_i(data_i), .ack(ack)
`ifdef MEM_INITIATOR_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- responder: acks after rsp_delay request cycles ----------------
    logic [7:0] mem [32];
    logic       mem_clr = 1'b1;
    logic       resp_en = 1'b1;
    int         rsp_delay = 0;
    int         rcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack  <= 1'b0;
            rcnt <= 0;
            if (mem_clr) for (int i = 0; i < 32; i++) mem[i] <= {3'b101, 5'(i)};
        end else if (ack) begin
            ack <= 1'b0;
        end else if ((read || write) && resp_en) begin
            if (rcnt == rsp_delay) begin
                ack  <= 1'b1;
                rcnt <= 0;
                if (write) mem[addr] <= data_o;
            end else begin
                rcnt <= rcnt + 1;
            end
        end else begin
            rcnt <= 0;
        end
    end

    assign data_i = ack ? mem[addr] : 8'hEE;

    // ---------------- scoring ----------------
    int tests = 0, failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- request-stability monitor ----------------
    int          viol = 0;
    logic        prev_req = 1'b0;
    logic [14:0] prev_bus = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            if (read && write) begin
                viol <= viol + 1;
                if (viol < 5) $display("FAIL rw_both: read=%b write=%b expected not both", read, write);
            end
            if (prev_req && (read || write) && ({read, write, addr, data_o} !== prev_bus)) begin
                viol <= viol + 1;
                if (viol < 5) $display("FAIL req_hold: bus %h expected %h", {read, write, addr, data_o}, prev_bus);
            end
            prev_req <= read || write;
            prev_bus <= {read, write, addr, data_o};
        end
    end

    // ---------------- behavioural model ----------------
    logic [7:0] model_mem [32];
    int         m_rd = 0, m_wr = 0, m_err = 0;
    logic       trace [64];

    function automatic int exp_latency(input int dly, input logic en);
        return (en && dly <= TMO - 2) ? dly + 2 : ERR_LAT;
    endfunction

    task automatic model_cmd(input logic w, input logic [4:0] a, input logic [7:0] d, input int dly,
                             output logic [7:0] erd, output logic eerr, output int elat);
        eerr = !(resp_en && dly <= TMO - 2);
        elat = exp_latency(dly, resp_en);
        erd  = 8'h00;
        if (!eerr) begin
            if (w) model_mem[a] = d;
            else   erd = model_mem[a];
        end
    endtask

    task automatic do_cmd(input logic w, input logic [4:0] a, input logic [7:0] d, input int dly,
                          input int hold, output logic [7:0] rd, output logic er, output int lat,
                          output int hold_bad);
        int guard = 0;
        rsp_delay = dly;
        hold_bad  = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 5'($urandom); cmd_wdata = 8'($urandom);
        lat = 0;
        trace[0] = read || write;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 64) trace[lat] = read || write;
        end
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || cmd_ready) hold_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid === 1'b0) begin
            if (er) m_err++; else if (w) m_wr++; else m_rd++;
        end
    endtask

    typedef struct {
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        int         dly;
        int         hold;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] rd, erd;
    logic       er, eerr;
    int         lat, elat, hb;

    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = {3'b101, 5'(i)};

        // write/read, ack on the timeout edge, held response, error paths, untouched pattern
        vecs[0]  = '{1'b1, 5'd3,  8'h5A, 0,  0,  8'h00, 1'b0, 2};
        vecs[1]  = '{1'b0, 5'd3,  8'h00, 0,  0,  8'h5A, 1'b0, 2};
        vecs[2]  = '{1'b1, 5'd10, 8'hC3, 14, 0,  8'h00, 1'b0, 16};
        vecs[3]  = '{1'b0, 5'd10, 8'h00, 2,  10, 8'hC3, 1'b0, 4};
        vecs[4]  = '{1'b0, 5'd0,  8'h11, 1,  0,  8'hA0, 1'b0, 3};
        vecs[5]  = '{1'b0, 5'd7,  8'h00, 40, 0,  8'h00, 1'b1, 50};
        vecs[6]  = '{1'b0, 5'd10, 8'h00, 15, 0,  8'h00, 1'b1, 50};
        vecs[7]  = '{1'b1, 5'd31, 8'hFF, 3,  0,  8'h00, 1'b0, 5};
        vecs[8]  = '{1'b0, 5'd31, 8'h00, 0,  0,  8'hFF, 1'b0, 2};
        vecs[9]  = '{1'b1, 5'd3,  8'h01, 40, 0,  8'h00, 1'b1, 50};
        vecs[10] = '{1'b0, 5'd3,  8'h00, 0,  0,  8'h5A, 1'b0, 2};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {read, write, addr, data_o, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) begin
            do_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dly, vecs[i].hold, rd, er, lat, hb);
            model_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dly, erd, eerr, elat);
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].hold > 0) check($sformatf("vec%0d_hold", i), 32'(hb), 32'd0);
        end

        // randomized commands against the model
        for (int n = 0; n < 200; n++) begin
            logic       w;
            logic [4:0] a;
            logic [7:0] d;
            int         r, dly, hold;
            w = 1'($urandom); a = 5'($urandom); d = 8'($urandom);
            r = int'($urandom_range(9, 0));
            dly  = (r < 7) ? r % 5 : (r == 7) ? 14 : (r == 8) ? 40 : (w ? 1 : 15);
            hold = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            model_cmd(w, a, d, dly, erd, eerr, elat);
            do_cmd(w, a, d, dly, hold, rd, er, lat, hb);
            check("rand_rdata", 32'(rd), 32'(erd));
            check("rand_err", 32'(er), 32'(eerr));
            check("rand_lat", 32'(lat), 32'(elat));
            if (hold > 0) check("rand_hold", 32'(hb), 32'd0);
        end

        // ack tied low: three 16-cycle windows separated by 1-cycle gaps
        resp_en = 1'b0;
        model_cmd(1'b0, 5'd7, 8'h00, 0, erd, eerr, elat);
        do_cmd(1'b0, 5'd7, 8'h00, 0, 0, rd, er, lat, hb);
        resp_en = 1'b1;
        begin
            int bad = 0;
            for (int k = 0; k <= ERR_LAT; k++)
                if (trace[k] !== ((k < ERR_LAT) && (k % (TMO + 1) != TMO))) bad++;
            check("tmo_windows", 32'(bad), 32'd0);
        end
        check("tmo_lat", 32'(lat), 32'(elat));
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_rdata", 32'(rd), 32'd0);

        // asynchronous reset in the second REQ cycle
        rsp_delay = 40;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("req_before_rst", 32'(read), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drops_req", {read, write}, 32'd0);
        check("rst_clears_rsp", {cmd_ready, rsp_valid, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0;
        model_cmd(1'b0, 5'd3, 8'h00, 1, erd, eerr, elat);
        do_cmd(1'b0, 5'd3, 8'h00, 1, 0, rd, er, lat, hb);
        check("post_rst_rdata", 32'(rd), 32'(erd));
        check("post_rst_err", 32'(er), 32'd0);

`ifdef MEM_INITIATOR_STATS_EN
        check("stats_rd_running", 32'(rd_cnt), 32'(m_rd));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_cmd(1'b1, 5'(i), 8'(8'h30 + i), 0, erd, eerr, elat);
            do_cmd(1'b1, 5'(i), 8'(8'h30 + i), 0, 0, rd, er, lat, hb);
        end
        for (int i = 0; i < 3; i++) begin
            model_cmd(1'b0, 5'(i), 8'h00, 1, erd, eerr, elat);
            do_cmd(1'b0, 5'(i), 8'h00, 1, 0, rd, er, lat, hb);
            check("stats_seq_rdata", 32'(rd), 32'(erd));
        end
        do_cmd(1'b0, 5'd9, 8'h00, 40, 0, rd, er, lat, hb);
        check("stats_wr", 32'(wr_cnt), 32'd4);
        check("stats_rd", 32'(rd_cnt), 32'd3);
        check("stats_err", 32'(err_cnt), 32'd1);
`endif

        check("req_stable", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
